// File: rtl/reader_pkg.sv
// Shared types and default sizing for the bridge frame reader.
package reader_pkg;

  // Sequencer states
  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWaitAck,
    StDrain
  } state_e;

  localparam int unsigned DefDataWidth = 128;
  localparam int unsigned DefAddrWidth = 26;
  localparam int unsigned DefLenWidth  = 16;
  localparam int unsigned DefFifoDepth = 16;

endpackage

// File: rtl/fwft_fifo.sv
// First-word-fall-through FIFO with occupancy count and synchronous flush.
module fwft_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned PtrWidth = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                push,
  input  logic [WIDTH-1:0]    push_data,
  input  logic                pop,
  output logic [WIDTH-1:0]    pop_data,
  output logic                empty,
  output logic [PtrWidth:0]   occupancy
);

  logic [WIDTH-1:0]    mem_q [DEPTH];
  logic [PtrWidth-1:0] wr_ptr_q, rd_ptr_q;
  logic [PtrWidth:0]   count_q;
  logic                full, do_push, do_pop;

  assign empty     = (count_q == '0);
  assign full      = (count_q == (PtrWidth + 1)'(DEPTH));
  assign occupancy = count_q;
  assign pop_data  = mem_q[rd_ptr_q];
  assign do_pop    = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is legal then.
  assign do_push   = push && (!full || do_pop);

  // Storage array; written only on an accepted push.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrWidth'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrWidth'(1);
      if (do_push && !do_pop)      count_q <= count_q + (PtrWidth + 1)'(1);
      else if (do_pop && !do_push) count_q <= count_q - (PtrWidth + 1)'(1);
    end
  end

endmodule

// File: rtl/bridge_frame_reader.sv
// Reads frame_count frames of word_count strided words over a single-outstanding
// bridge and streams them out through a FWFT buffer with frame tags.
module bridge_frame_reader
  import reader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned ADDR_WIDTH = DefAddrWidth,
  parameter int unsigned LEN_WIDTH  = DefLenWidth,
  parameter int unsigned FIFO_DEPTH = DefFifoDepth
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    abort,
  input  logic [ADDR_WIDTH-1:0]   base_addr,
  input  logic [LEN_WIDTH-1:0]    word_count,
  input  logic [ADDR_WIDTH-1:0]   word_stride,
  input  logic [LEN_WIDTH-1:0]    frame_count,
  input  logic [ADDR_WIDTH-1:0]   frame_stride,
  output logic [ADDR_WIDTH-1:0]   interface_address,
  output logic [DATA_WIDTH/8-1:0] interface_byte_enable,
  output logic                    interface_read,
  input  logic                    interface_acknowledge,
  input  logic [DATA_WIDTH-1:0]   interface_read_data,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last_word,
  output logic                    out_last_frame,
  output logic                    busy,
  output logic                    done,
  output logic                    aborted
);

  localparam int unsigned OccWidth = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned BeWidth  = DATA_WIDTH / 8;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, frame_base_q, frame_base_d;
  logic [ADDR_WIDTH-1:0] ws_q, ws_d, fs_q, fs_d;
  logic [LEN_WIDTH-1:0]  wc_q, wc_d, fc_q, fc_d;
  logic [LEN_WIDTH-1:0]  word_idx_q, word_idx_d, frame_idx_q, frame_idx_d;
  logic                  read_q, read_d, abort_q, abort_d;
  logic                  done_q, done_d, aborted_q, aborted_d;

  logic                  fifo_push, fifo_pop, fifo_flush, fifo_empty;
  logic [DATA_WIDTH+1:0] fifo_wdata, fifo_rdata;
  logic [OccWidth-1:0]   fifo_occ;
  logic                  last_word, last_frame;

  assign last_word  = (word_idx_q == wc_q - LEN_WIDTH'(1));
  assign last_frame = (frame_idx_q == fc_q - LEN_WIDTH'(1));
  assign fifo_wdata = {last_word, last_frame, interface_read_data};
  assign fifo_pop   = out_valid && out_ready;

  fwft_fifo #(
    .WIDTH (DATA_WIDTH + 2),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (fifo_flush),
    .push      (fifo_push),
    .push_data (fifo_wdata),
    .pop       (fifo_pop),
    .pop_data  (fifo_rdata),
    .empty     (fifo_empty),
    .occupancy (fifo_occ)
  );

  // Stream and bridge outputs; tags gated so they read zero while the buffer is empty.
  always_comb begin
    out_valid             = !fifo_empty;
    out_data              = fifo_rdata[DATA_WIDTH-1:0];
    out_last_word         = out_valid && fifo_rdata[DATA_WIDTH+1];
    out_last_frame        = out_valid && fifo_rdata[DATA_WIDTH];
    interface_read        = read_q;
    interface_address     = addr_q;
    interface_byte_enable = {BeWidth{read_q}};
    busy                  = (state_q != StIdle);
    done                  = done_q;
    aborted               = aborted_q;
  end

  // Sequencer next-state: walks words within a frame, then frames, one read at a time.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    frame_base_d = frame_base_q;
    ws_d         = ws_q;
    fs_d         = fs_q;
    wc_d         = wc_q;
    fc_d         = fc_q;
    word_idx_d   = word_idx_q;
    frame_idx_d  = frame_idx_q;
    read_d       = read_q;
    abort_d      = abort_q;
    done_d       = 1'b0;
    aborted_d    = 1'b0;
    fifo_push    = 1'b0;
    fifo_flush   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start && !abort) begin
          addr_d       = base_addr;
          frame_base_d = base_addr;
          ws_d         = word_stride;
          fs_d         = frame_stride;
          wc_d         = word_count;
          fc_d         = frame_count;
          word_idx_d   = '0;
          frame_idx_d  = '0;
          abort_d      = 1'b0;
          // An empty command just drains an already-empty buffer and completes.
          state_d = (word_count == '0 || frame_count == '0) ? StDrain : StIssue;
        end
      end
      StIssue: begin
        if (abort) begin
          fifo_flush = 1'b1;
          aborted_d  = 1'b1;
          state_d    = StIdle;
        end else if (fifo_occ < OccWidth'(FIFO_DEPTH)) begin
          read_d  = 1'b1;
          state_d = StWaitAck;
        end
      end
      StWaitAck: begin
        if (abort) abort_d = 1'b1;
        if (interface_acknowledge) begin
          read_d = 1'b0;
          if (abort_q || abort) begin
            // Outstanding read completed; its data is dropped with the buffer.
            fifo_flush = 1'b1;
            aborted_d  = 1'b1;
            abort_d    = 1'b0;
            state_d    = StIdle;
          end else begin
            fifo_push = 1'b1;
            if (!last_word) begin
              addr_d     = addr_q + ws_q;
              word_idx_d = word_idx_q + LEN_WIDTH'(1);
              state_d    = StIssue;
            end else if (!last_frame) begin
              frame_base_d = frame_base_q + fs_q;
              addr_d       = frame_base_q + fs_q;
              word_idx_d   = '0;
              frame_idx_d  = frame_idx_q + LEN_WIDTH'(1);
              state_d      = StIssue;
            end else begin
              state_d = StDrain;
            end
          end
        end
      end
      StDrain: begin
        if (abort) begin
          fifo_flush = 1'b1;
          aborted_d  = 1'b1;
          state_d    = StIdle;
        end else if (fifo_empty) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      frame_base_q <= '0;
      ws_q         <= '0;
      fs_q         <= '0;
      wc_q         <= '0;
      fc_q         <= '0;
      word_idx_q   <= '0;
      frame_idx_q  <= '0;
      read_q       <= 1'b0;
      abort_q      <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      frame_base_q <= frame_base_d;
      ws_q         <= ws_d;
      fs_q         <= fs_d;
      wc_q         <= wc_d;
      fc_q         <= fc_d;
      word_idx_q   <= word_idx_d;
      frame_idx_q  <= frame_idx_d;
      read_q       <= read_d;
      abort_q      <= abort_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
    end
  end

endmodule

// File: tb/tb_bridge_frame_reader.sv
// Randomised bench for bridge_frame_reader with a bridge responder, a stream
// consumer and an address/stream model derived from the frame arithmetic.
module tb_bridge_frame_reader;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 26;
  localparam int unsigned LW = 16;
  localparam int unsigned FD = 4;
  localparam int unsigned BW = DW / 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          start, abort;
  logic [AW-1:0] base_addr, word_stride, frame_stride;
  logic [LW-1:0] word_count, frame_count;
  logic [AW-1:0] interface_address;
  logic [BW-1:0] interface_byte_enable;
  logic          interface_read, interface_acknowledge;
  logic [DW-1:0] interface_read_data;
  logic [DW-1:0] out_data;
  logic          out_valid, out_ready, out_last_word, out_last_frame;
  logic          busy, done, aborted;

  bridge_frame_reader #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .LEN_WIDTH  (LW),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk                   (clk),
    .reset                 (reset),
    .start                 (start),
    .abort                 (abort),
    .base_addr             (base_addr),
    .word_count            (word_count),
    .word_stride           (word_stride),
    .frame_count           (frame_count),
    .frame_stride          (frame_stride),
    .interface_address     (interface_address),
    .interface_byte_enable (interface_byte_enable),
    .interface_read        (interface_read),
    .interface_acknowledge (interface_acknowledge),
    .interface_read_data   (interface_read_data),
    .out_data              (out_data),
    .out_valid             (out_valid),
    .out_ready             (out_ready),
    .out_last_word         (out_last_word),
    .out_last_frame        (out_last_frame),
    .busy                  (busy),
    .done                  (done),
    .aborted               (aborted)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Model of the current command
  logic [AW-1:0] cur_base;
  int unsigned   cur_wc, cur_ws, cur_fc, cur_fs;
  int unsigned   ack_delay = 0;
  int unsigned   ready_mode = 1;
  bit            resp_en = 1'b1;

  logic [DW-1:0] ret_q[$];
  logic [AW-1:0] addr_log[$];
  int unsigned   req_cnt, str_idx, done_cnt, aborted_cnt;

  function automatic logic [AW-1:0] model_addr(input int unsigned r);
    longint unsigned f, w, s;
    f = r / cur_wc;
    w = r % cur_wc;
    s = longint'(cur_base) + f * cur_fs + w * cur_ws;
    return s[AW-1:0];
  endfunction

  // Bridge responder: acknowledges each read after ack_delay extra cycles.
  initial begin
    logic [AW-1:0] a;
    interface_acknowledge = 1'b0;
    interface_read_data   = '0;
    forever begin
      @(posedge clk); #1;
      if (resp_en && interface_read === 1'b1) begin
        a = interface_address;
        addr_log.push_back(a);
        check_eq("be_on", interface_byte_enable, {BW{1'b1}});
        if (cur_wc != 0) check_eq("addr", a, model_addr(req_cnt));
        req_cnt++;
        for (int i = 0; i < int'(ack_delay); i++) begin
          @(posedge clk); #1;
          check_eq("read_hold", interface_read, 1'b1);
          check_eq("addr_hold", interface_address, a);
        end
        interface_acknowledge = 1'b1;
        interface_read_data   = $urandom;
        @(posedge clk); #1;
        ret_q.push_back(interface_read_data);
        interface_acknowledge = 1'b0;
        check_eq("read_drop", interface_read, 1'b0);
        check_eq("be_off", interface_byte_enable, '0);
      end
    end
  end

  // Stream consumer
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: pulse counts, stream ordering/tags, stall stability.
  initial begin
    logic          prev_stall;
    logic [DW+1:0] prev_word;
    logic          exp_lw, exp_lf;
    prev_stall = 1'b0;
    prev_word  = '0;
    forever begin
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
      if (aborted === 1'b1) aborted_cnt++;
      if (prev_stall && out_valid === 1'b1)
        check_eq("stall_hold", {out_last_word, out_last_frame, out_data}, prev_word);
      prev_stall = (out_valid === 1'b1) && (out_ready === 1'b0);
      prev_word  = {out_last_word, out_last_frame, out_data};
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        if (str_idx < ret_q.size()) check_eq("data", out_data, ret_q[str_idx]);
        else check_eq("extra_word", str_idx, ret_q.size());
        if (cur_wc != 0) begin
          exp_lw = ((str_idx % cur_wc) == cur_wc - 1);
          exp_lf = ((str_idx / cur_wc) == cur_fc - 1);
          check_eq("last_word", out_last_word, exp_lw);
          check_eq("last_frame", out_last_frame, exp_lf);
        end
        str_idx++;
      end
    end
  end

  task automatic clear_model();
    req_cnt = 0;
    str_idx = 0;
    done_cnt = 0;
    aborted_cnt = 0;
    ret_q.delete();
    addr_log.delete();
  endtask

  task automatic wait_idle(input int unsigned max_cycles);
    bit timed_out;
    timed_out = 1'b1;
    for (int i = 0; i < int'(max_cycles); i++) begin
      @(posedge clk); #1;
      if (!busy) begin
        timed_out = 1'b0;
        break;
      end
    end
    check_eq("idle_timeout", timed_out, 1'b0);
  endtask

  task automatic issue_start(input logic [AW-1:0] b, input int unsigned wc, input int unsigned ws,
                             input int unsigned fc, input int unsigned fs);
    cur_base = b; cur_wc = wc; cur_ws = ws; cur_fc = fc; cur_fs = fs;
    clear_model();
    @(posedge clk); #1;
    base_addr    = b;
    word_count   = LW'(wc);
    word_stride  = AW'(ws);
    frame_count  = LW'(fc);
    frame_stride = AW'(fs);
    start        = 1'b1;
    @(posedge clk); #1;
    start        = 1'b0;
    // Scramble inputs so only latched values can produce the right addresses.
    base_addr    = AW'($urandom);
    word_count   = LW'($urandom);
    word_stride  = AW'($urandom);
    frame_count  = LW'($urandom);
    frame_stride = AW'($urandom);
    check_eq("busy_rise", busy, 1'b1);
  endtask

  task automatic run_cmd(input logic [AW-1:0] b, input int unsigned wc, input int unsigned ws,
                         input int unsigned fc, input int unsigned fs);
    issue_start(b, wc, ws, fc, fs);
    if (wc * fc >= 3) begin
      @(posedge clk); #1; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
    end
    wait_idle(4000);
    @(posedge clk); #1;
    check_eq("req_count", req_cnt, wc * fc);
    check_eq("word_count", str_idx, wc * fc);
    check_eq("done_once", done_cnt, 1);
    check_eq("no_abort", aborted_cnt, 0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    base_addr = '0; word_count = '0; word_stride = '0; frame_count = '0; frame_stride = '0;
    cur_wc = 0; cur_fc = 0; cur_ws = 0; cur_fs = 0; cur_base = '0;
    clear_model();
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_read", interface_read, 1'b0);
    check_eq("rst_addr", interface_address, '0);
    check_eq("rst_be", interface_byte_enable, '0);
    check_eq("rst_valid", out_valid, 1'b0);
    check_eq("rst_lw", out_last_word, 1'b0);
    check_eq("rst_lf", out_last_frame, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_aborted", aborted, 1'b0);
    reset = 1'b0;

    // Single frame, ack one cycle after read
    ack_delay = 0; ready_mode = 1;
    run_cmd(26'h100, 4, 16, 1, 0);
    for (int i = 0; i < 4; i++)
      if (i < addr_log.size()) check_eq("seq_addr", addr_log[i], 26'h100 + 26'(16 * i));

    // Two frames
    run_cmd(26'h0, 3, 16, 2, 26'h1000);
    if (addr_log.size() == 6) check_eq("frame2_addr", addr_log[3], 26'h1000);

    // Zero-length command: busy one cycle, done two cycles after start
    issue_start(26'h55, 0, 4, 3, 0);
    @(posedge clk); #1;
    check_eq("zero_busy_fall", busy, 1'b0);
    check_eq("zero_done", done, 1'b1);
    @(posedge clk); #1;
    check_eq("zero_done_pulse", done, 1'b0);
    check_eq("zero_no_read", req_cnt, 0);

    // Address wrap
    run_cmd(26'h3FFFFF0, 2, 16, 1, 0);
    if (addr_log.size() == 2) check_eq("wrap_addr", addr_log[1], '0);

    // Backpressure: buffer fills, reads stop
    ready_mode = 0;
    issue_start(26'h2000, 10, 4, 1, 0);
    repeat (40) @(posedge clk);
    #1;
    check_eq("bp_reads", req_cnt, FD);
    check_eq("bp_read_low", interface_read, 1'b0);
    check_eq("bp_valid", out_valid, 1'b1);
    ready_mode = 1;
    wait_idle(2000);
    @(posedge clk); #1;
    check_eq("bp_words", str_idx, 10);
    check_eq("bp_req_total", req_cnt, 10);
    check_eq("bp_done", done_cnt, 1);

    // Abort with read outstanding and slow acknowledge
    ready_mode = 0; ack_delay = 5;
    issue_start(26'h300, 8, 8, 1, 0);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #2;
      if (req_cnt == 3) break;
    end
    check_eq("abort_reached", req_cnt, 3);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    wait_idle(100);
    repeat (5) @(posedge clk);
    #1;
    check_eq("abort_pulse", aborted_cnt, 1);
    check_eq("abort_no_done", done_cnt, 0);
    check_eq("abort_empty", out_valid, 1'b0);
    check_eq("abort_no_more_reads", req_cnt, 3);
    check_eq("abort_read_low", interface_read, 1'b0);

    // Abort in idle ignored; start with abort ignored
    ack_delay = 0; ready_mode = 1;
    clear_model();
    @(posedge clk); #1; abort = 1'b1;
    @(posedge clk); #1; abort = 1'b0;
    word_count = 2; frame_count = 1; start = 1'b1; abort = 1'b1;
    @(posedge clk); #1; start = 1'b0; abort = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_eq("idle_abort_busy", busy, 1'b0);
    check_eq("idle_abort_pulse", aborted_cnt, 0);
    check_eq("idle_abort_reads", req_cnt, 0);

    // Randomised commands
    for (int n = 0; n < 10; n++) begin
      ack_delay  = $urandom_range(0, 3);
      ready_mode = 2;
      run_cmd(AW'($urandom), $urandom_range(1, 5), $urandom_range(0, 3) * 16 + 4,
              $urandom_range(1, 3), $urandom_range(0, 1 << 20));
    end

    // Asynchronous reset in the middle of a pending read
    ready_mode = 1; ack_delay = 0;
    resp_en = 1'b0;
    issue_start(26'h40, 2, 16, 1, 0);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (interface_read) break;
    end
    check_eq("rst_mid_read_seen", interface_read, 1'b1);
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    check_eq("rst_mid_read", interface_read, 1'b0);
    check_eq("rst_mid_addr", interface_address, '0);
    check_eq("rst_mid_be", interface_byte_enable, '0);
    check_eq("rst_mid_busy", busy, 1'b0);
    check_eq("rst_mid_valid", out_valid, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    interface_acknowledge = 1'b1;
    interface_read_data   = 32'hDEADBEEF;
    repeat (2) @(posedge clk);
    #1;
    interface_acknowledge = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("late_ack_no_push", out_valid, 1'b0);
    check_eq("late_ack_idle", busy, 1'b0);
    check_eq("late_ack_no_done", done_cnt, 0);
    resp_en = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bridge_frame_reader.md
BRIDGE_FRAME_READER -- requirements
Module: bridge_frame_reader

Interface
REQ-001 Parameter DATA_WIDTH, 128, bridge read-data and stream width in bits (multiple of 8).
REQ-002 Parameter ADDR_WIDTH, 26, bridge byte-address width.
REQ-003 Parameter LEN_WIDTH, 16, width of word-count and frame-count fields.
REQ-004 Parameter FIFO_DEPTH, 16, output buffer depth in words (power of 2, >=2).
REQ-005 Ports, one per line:
- clk  in  1  single clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high.
- start  in  1  one-cycle command pulse.
- abort  in  1  one-cycle cancel pulse.
- base_addr  in  ADDR_WIDTH  first word byte address.
- word_count  in  LEN_WIDTH  words per frame.
- word_stride  in  ADDR_WIDTH  byte step between words.
- frame_count  in  LEN_WIDTH  number of frames.
- frame_stride  in  ADDR_WIDTH  byte step between frame bases.
- interface_address  out  ADDR_WIDTH  bridge address.
- interface_byte_enable  out  DATA_WIDTH/8  bridge byte enables.
- interface_read  out  1  bridge read request.
- interface_acknowledge  in  1  bridge completion.
- interface_read_data  in  DATA_WIDTH  bridge data, valid with acknowledge.
- out_data  out  DATA_WIDTH  stream word.
- out_valid  out  1  stream word available.
- out_ready  in  1  consumer accepts.
- out_last_word  out  1  word is last of its frame.
- out_last_frame  out  1  word belongs to final frame.
- busy  out  1  command in progress.
- done  out  1  one-cycle completion pulse.
- aborted  out  1  one-cycle abort-complete pulse.

Function
REQ-006 FSM states IDLE, ISSUE, WAIT_ACK, DRAIN; IDLE on reset.
REQ-007 start in IDLE latches all command inputs, sets busy next cycle; start while busy is ignored.
REQ-008 word_count==0 or frame_count==0: no bridge read, done pulses 2 cycles after start, busy high exactly 1 cycle.
REQ-009 ISSUE -> WAIT_ACK asserting interface_read only when FIFO occupancy <= FIFO_DEPTH-1; otherwise remain in ISSUE with read low.
REQ-010 interface_read, interface_address stay constant from assertion through the cycle acknowledge is sampled high; read deasserts the following cycle, minimum one low cycle between requests.
REQ-011 interface_byte_enable is all ones whenever read is high, zero otherwise.
REQ-012 Data is pushed to the FIFO in the acknowledge cycle with its frame-end and final-frame tags.
REQ-013 Address for word w of frame f = base_addr + f*frame_stride + w*word_stride, computed incrementally, modulo 2^ADDR_WIDTH (wrap without error).
REQ-014 After the last word of the last frame is acknowledged, go to DRAIN; done pulses and busy falls in the cycle after the FIFO becomes empty.
REQ-015 FIFO is first-word-fall-through: out_valid = not empty; pop on out_valid && out_ready; simultaneous push and pop when full is legal and keeps occupancy constant.
REQ-016 abort while busy: if a read is outstanding, keep it until acknowledge and discard that data; then flush FIFO, pulse aborted, return to IDLE; done does not pulse; abort in IDLE is ignored.
REQ-017 start and abort in the same cycle in IDLE: start is ignored.
REQ-018 Stream outputs never change while out_valid && !out_ready.

Reset
REQ-019 On reset: interface_read=0, interface_address=0, byte_enable=0, out_valid=0, out_last_word=0, out_last_frame=0, busy=0, done=0, aborted=0, FIFO empty, all counters zero, state IDLE.
REQ-020 Reset during WAIT_ACK drops interface_read immediately; any later acknowledge while IDLE is ignored.

Structure
REQ-021 Package reader_pkg holds the FSM state enum and default parameter constants.
REQ-022 Sub-module fwft_fifo (parametrised width/depth, occupancy output) implements the buffer; the remainder is the sequencer in bridge_frame_reader.

Verification
REQ-023 base 0x100, word_stride 16, word_count 4, frame_count 1, ready=1, ack 1 cycle after read -> addresses 0x100,0x110,0x120,0x130, 4 words in order, last_word on 4th, done once.
REQ-024 word_count 3, frame_count 2, frame_stride 0x1000 -> addresses 0x0,0x10,0x20,0x1000,0x1010,0x1020; last_word on words 3 and 6; last_frame on words 4-6.
REQ-025 FIFO_DEPTH 4, out_ready=0, word_count 10 -> exactly 4 reads issued, read stays low; release ready -> remaining 6 words, no loss or duplication.
REQ-026 abort while read outstanding, ack delayed 5 cycles -> read held until ack, data discarded, FIFO empty, aborted pulses once, done never.
REQ-027 word_count 0 -> no read, done 2 cycles after start; base 0x3FFFFF0, stride 16, 2 words -> second address 0x0000000.
REQ-028 Async reset asserted mid-WAIT_ACK -> all outputs at reset values in same cycle; late ack produces no FIFO push.
